puck_animator: RTL and testbench

- Upstream control stage for the rectangle `drawable` datapath.
- Once per frame it sequences two rectangle draws for the moving puck:
  - erase the old puck footprint in black;
  - step the position with wall bounce;
  - draw the puck at the new position.
- Drives `drawable`'s geometry, colour and enable inputs, and consumes its `y_count_done` as the completion handshake.

---
 rtl/air_hockey_pkg.sv | 18 +
 rtl/frame_tick_counter.sv | 34 +++
 rtl/puck_animator.sv | 150 +++++++++++++++
 tb/tb_puck_animator.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/air_hockey_pkg.sv
// Shared constants and FSM state encoding for the air-hockey display pipeline.
package air_hockey_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        WAIT       = 3'd0,
        ERASE_LOAD = 3'd1,
        ERASE      = 3'd2,
        UPDATE     = 3'd3,
        DRAW_LOAD  = 3'd4,
        DRAW       = 3'd5
    } state_e;

endpackage

// File: rtl/frame_tick_counter.sv
// Free-running frame divider: emits a 1-cycle tick on the terminal count while enabled.
module frame_tick_counter #(
    parameter int unsigned FRAME_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset_n,
    input  logic count_en,
    output logic tick
);

    localparam int unsigned CountW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CountW-1:0] LastCount = CountW'(FRAME_CYCLES - 1);

    logic [CountW-1:0] count_q, count_d;

    assign tick = count_en && (count_q == LastCount);

    // Counter only advances while enabled, so a disabled period simply stretches the frame.
    always_comb begin
        count_d = count_q;
        if (count_en) begin
            count_d = tick ? '0 : count_q + CountW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/puck_animator.sv
// Per-frame erase / move / redraw sequencer for the puck, driving the rectangle drawable.
module puck_animator
    import air_hockey_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned PUCK_DIM     = 4,
    parameter int unsigned X_MAX        = SCREEN_W - 1,
    parameter int unsigned Y_MAX        = SCREEN_H - 1,
    parameter int unsigned X_START      = 80,
    parameter int unsigned Y_START      = 60,
    parameter logic [2:0]  PUCK_COLOUR  = 3'b111
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       draw_done,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [7:0] width,
    output logic [6:0] height,
    output logic [2:0] colour,
    output logic       enable,
    output logic       reset_draw,
    output logic       writeEn,
    output logic [7:0] puck_x,
    output logic [6:0] puck_y
);

    localparam logic [8:0] XLimit = 9'(X_MAX);
    localparam logic [8:0] XDim   = 9'(PUCK_DIM);
    localparam logic [7:0] YLimit = 8'(Y_MAX);
    localparam logic [7:0] YDim   = 8'(PUCK_DIM);

    state_e     state_q, state_d;
    logic [7:0] puck_x_q, puck_x_d;
    logic [6:0] puck_y_q, puck_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic [8:0] x_ext;
    logic [7:0] y_ext;
    logic       count_en;
    logic       tick;

    assign count_en = run && (state_q == WAIT);

    frame_tick_counter #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .count_en(count_en),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        puck_x_d = puck_x_q;
        puck_y_d = puck_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        x_ext    = {1'b0, puck_x_q};
        y_ext    = {1'b0, puck_y_q};
        unique case (state_q)
            WAIT:       if (tick) state_d = ERASE_LOAD;
            ERASE_LOAD: state_d = ERASE;
            ERASE:      if (draw_done) state_d = UPDATE;
            UPDATE: begin
                // Widened intermediates keep position + PUCK_DIM from wrapping near the wall.
                if (dir_x_q) begin
                    if (x_ext + XDim < XLimit) begin
                        x_ext = x_ext + 9'd1;
                    end else begin
                        dir_x_d = 1'b0;
                        x_ext   = x_ext - 9'd1;
                    end
                end else if (x_ext != '0) begin
                    x_ext = x_ext - 9'd1;
                end else begin
                    dir_x_d = 1'b1;
                    x_ext   = x_ext + 9'd1;
                end
                if (dir_y_q) begin
                    if (y_ext + YDim < YLimit) begin
                        y_ext = y_ext + 8'd1;
                    end else begin
                        dir_y_d = 1'b0;
                        y_ext   = y_ext - 8'd1;
                    end
                end else if (y_ext != '0) begin
                    y_ext = y_ext - 8'd1;
                end else begin
                    dir_y_d = 1'b1;
                    y_ext   = y_ext + 8'd1;
                end
                puck_x_d = x_ext[7:0];
                puck_y_d = y_ext[6:0];
                state_d  = DRAW_LOAD;
            end
            DRAW_LOAD:  state_d = DRAW;
            DRAW:       if (draw_done) state_d = WAIT;
            default:    state_d = WAIT;
        endcase
    end

    // Outputs are forced idle while reset is held, independent of the registered state.
    always_comb begin
        x_pos      = '0;
        y_pos      = '0;
        width      = '0;
        height     = '0;
        colour     = COLOUR_BLACK;
        enable     = 1'b0;
        writeEn    = 1'b0;
        reset_draw = 1'b1;
        if (reset_n) begin
            if (state_q inside {ERASE_LOAD, ERASE, DRAW_LOAD, DRAW}) begin
                x_pos  = puck_x_q;
                y_pos  = puck_y_q;
                width  = 8'(PUCK_DIM);
                height = 7'(PUCK_DIM);
                colour = (state_q inside {DRAW_LOAD, DRAW}) ? PUCK_COLOUR : COLOUR_BLACK;
            end
            if (state_q inside {ERASE, DRAW}) begin
                enable     = 1'b1;
                writeEn    = 1'b1;
                reset_draw = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= DRAW_LOAD;
            puck_x_q <= 8'(X_START);
            puck_y_q <= 7'(Y_START);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            puck_x_q <= puck_x_d;
            puck_y_q <= puck_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
        end
    end

    assign puck_x = puck_x_q;
    assign puck_y = puck_y_q;

endmodule

// File: tb/tb_puck_animator.sv
// Randomised scoreboard bench for puck_animator against a closed-form bouncing-position model.
module tb_puck_animator;

    localparam int unsigned FRAME_CYCLES = 4;
    localparam int unsigned PUCK_DIM     = 4;
    localparam int unsigned X_MAX        = 159;
    localparam int unsigned Y_MAX        = 119;
    localparam int unsigned X_START      = 80;
    localparam int unsigned Y_START      = 60;
    localparam logic [2:0]  PUCK_COLOUR  = 3'b111;
    localparam int FRAMES_AHEAD = 300;
    localparam int RAND_FRAMES  = 270;
    localparam int KIND_INIT  = 0;
    localparam int KIND_ERASE = 1;
    localparam int KIND_DRAW  = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int col;
    } item_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic       draw_done;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [7:0] width;
    logic [6:0] height;
    logic [2:0] colour;
    logic       enable;
    logic       reset_draw;
    logic       writeEn;
    logic [7:0] puck_x;
    logic [6:0] puck_y;

    item_t exp_q[$];
    int n_checks    = 0;
    int n_fail      = 0;
    int timeout_req = 0;
    int timeout_ack = 0;
    int stray_cnt   = 0;
    int stray_done  = 0;
    int lat_fixed   = 0;
    int items_done  = 0;
    int active_kind = -1;
    bit after_draw  = 1'b0;

    puck_animator #(
        .FRAME_CYCLES(FRAME_CYCLES),
        .PUCK_DIM    (PUCK_DIM),
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .X_START     (X_START),
        .Y_START     (Y_START),
        .PUCK_COLOUR (PUCK_COLOUR)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .draw_done (draw_done),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .width     (width),
        .height    (height),
        .colour    (colour),
        .enable    (enable),
        .reset_draw(reset_draw),
        .writeEn   (writeEn),
        .puck_x    (puck_x),
        .puck_y    (puck_y)
    );

    always #5 clock = ~clock;

    // Bouncing coordinate after k moves: a triangle wave over [0, span].
    function automatic int bounce(input int start, input int k, input int span);
        int t;
        t = (start + k) % (2 * span);
        return (t <= span) ? t : 2 * span - t;
    endfunction

    task automatic push_item(input int kind, input int x, input int y, input int col);
        item_t it;
        it.kind = kind;
        it.x    = x;
        it.y    = y;
        it.col  = col;
        exp_q.push_back(it);
    endtask

    task automatic push_model();
        int lx = int'(X_MAX - PUCK_DIM);
        int ly = int'(Y_MAX - PUCK_DIM);
        int sx = int'(X_START);
        int sy = int'(Y_START);
        push_item(KIND_INIT, sx, sy, int'(PUCK_COLOUR));
        for (int k = 1; k <= FRAMES_AHEAD; k++) begin
            push_item(KIND_ERASE, bounce(sx, k - 1, lx), bounce(sy, k - 1, ly), 0);
            push_item(KIND_DRAW, bounce(sx, k, lx), bounce(sy, k, ly), int'(PUCK_COLOUR));
        end
    endtask

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_items(input int n);
        int i = 0;
        while (items_done < n && i < 5000) begin
            step(1);
            i++;
        end
        if (items_done < n) timeout_req++;
    endtask

    task automatic wait_kind(input int k);
        int i = 0;
        while (active_kind != k && i < 5000) begin
            step(1);
            i++;
        end
        if (active_kind != k) timeout_req++;
    endtask

    task automatic wait_after_draw();
        int i = 0;
        while (!after_draw && i < 5000) begin
            step(1);
            i++;
        end
        if (!after_draw) timeout_req++;
    endtask

    // draw_done stub: pulses once per rectangle after a random (or forced) latency.
    initial begin
        bit in_draw;
        int remain;
        in_draw   = 1'b0;
        remain    = 0;
        draw_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (draw_done) begin
                draw_done = 1'b0;
            end else if (stray_cnt != stray_done) begin
                draw_done  = 1'b1;
                stray_done = stray_cnt;
            end else if (enable && reset_n) begin
                if (!in_draw) begin
                    in_draw = 1'b1;
                    remain  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(0, 24));
                end
                if (remain == 0) draw_done = 1'b1;
                else remain--;
            end
            if (!enable || !reset_n) in_draw = 1'b0;
        end
    end

    // Monitor: pops an expected rectangle each time a draw starts and checks it cycle by cycle.
    initial begin
        item_t      cur;
        int         gap_len;
        int         gap_run;
        int         last_run;
        int         rst_cycles;
        bit         prev_en;
        logic [7:0] px;
        logic [6:0] py;
        logic [7:0] pw;
        logic [6:0] ph;
        logic [2:0] pc;
        cur.kind   = -1;
        cur.x      = 0;
        cur.y      = 0;
        cur.col    = 0;
        gap_len    = 0;
        gap_run    = 0;
        last_run   = 0;
        rst_cycles = 0;
        prev_en    = 1'b0;
        forever begin
            @(negedge clock);
            if (timeout_req != timeout_ack) begin
                chk(1'b0, "wait_timeout", timeout_req, timeout_ack);
                timeout_ack = timeout_req;
            end
            if (!reset_n) begin
                rst_cycles++;
                exp_q.delete();
                active_kind = -1;
                after_draw  = 1'b0;
                gap_len     = 0;
                gap_run     = 0;
                chk(enable == 1'b0, "rst_enable", int'(enable), 0);
                chk(writeEn == 1'b0, "rst_writeEn", int'(writeEn), 0);
                chk(reset_draw == 1'b1, "rst_reset_draw", int'(reset_draw), 1);
                chk(colour == 3'b000, "rst_colour", int'(colour), 0);
                chk(x_pos == 8'd0 && y_pos == 7'd0, "rst_pos", int'(x_pos), 0);
                chk(width == 8'd0 && height == 7'd0, "rst_size", int'(width), 0);
                if (rst_cycles >= 2) begin
                    chk(int'(puck_x) == int'(X_START), "rst_puck_x", int'(puck_x), int'(X_START));
                    chk(int'(puck_y) == int'(Y_START), "rst_puck_y", int'(puck_y), int'(Y_START));
                end
            end else begin
                rst_cycles = 0;
                chk(writeEn == enable, "writeEn_follows_draw", int'(writeEn), int'(enable));
                chk(reset_draw == !enable, "reset_draw_idle", int'(reset_draw), int'(!enable));
                if (enable && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "queue_empty", 0, 1);
                        cur.kind = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        chk(int'(px) == cur.x, "load_x", int'(px), cur.x);
                        chk(int'(py) == cur.y, "load_y", int'(py), cur.y);
                        chk(int'(pc) == cur.col, "load_colour", int'(pc), cur.col);
                        chk(int'(pw) == int'(PUCK_DIM) && int'(ph) == int'(PUCK_DIM),
                            "load_size", int'(pw), int'(PUCK_DIM));
                        if (cur.kind == KIND_INIT) begin
                            chk(gap_len == 1, "init_gap", gap_len, 1);
                        end else if (cur.kind == KIND_ERASE) begin
                            chk(gap_run - last_run == int'(FRAME_CYCLES), "frame_wait",
                                gap_run - last_run, int'(FRAME_CYCLES));
                        end else begin
                            chk(gap_len == 2, "update_gap", gap_len, 2);
                        end
                        chk(int'(puck_x) == cur.x, "puck_x", int'(puck_x), cur.x);
                        chk(int'(puck_y) == cur.y, "puck_y", int'(puck_y), cur.y);
                    end
                    active_kind = cur.kind;
                    after_draw  = 1'b0;
                end
                if (enable && cur.kind >= 0) begin
                    chk(int'(x_pos) == cur.x, "x_pos", int'(x_pos), cur.x);
                    chk(int'(y_pos) == cur.y, "y_pos", int'(y_pos), cur.y);
                    chk(int'(colour) == cur.col, "colour", int'(colour), cur.col);
                    chk(int'(width) == int'(PUCK_DIM), "width", int'(width), int'(PUCK_DIM));
                    chk(int'(height) == int'(PUCK_DIM), "height", int'(height), int'(PUCK_DIM));
                end
                if (!enable) begin
                    if (prev_en) begin
                        items_done++;
                        if (active_kind == KIND_DRAW || active_kind == KIND_INIT) after_draw = 1'b1;
                        active_kind = -1;
                        gap_len     = 0;
                        gap_run     = 0;
                    end
                    gap_len++;
                    gap_run += int'(run);
                    last_run = int'(run);
                end
            end
            prev_en = enable && reset_n;
            px = x_pos;
            py = y_pos;
            pw = width;
            ph = height;
            pc = colour;
        end
    end

    initial begin
        int target;
        reset_n = 1'b0;
        run     = 1'b1;
        step(3);
        reset_n = 1'b1;
        push_model();
        wait_items(5);

        // Freeze in WAIT for 100 cycles.
        wait_after_draw();
        run = 1'b0;
        step(100);
        run = 1'b1;

        // Drop run in the middle of a long draw; it must still complete.
        lat_fixed = 20;
        wait_kind(KIND_ERASE);
        wait_kind(KIND_DRAW);
        step(5);
        run = 1'b0;
        step(60);
        run = 1'b1;
        wait_items(items_done + 2);

        // Reset 10 cycles into an erase.
        lat_fixed = 40;
        wait_kind(KIND_DRAW);
        wait_kind(KIND_ERASE);
        step(10);
        reset_n = 1'b0;
        step(3);
        reset_n   = 1'b1;
        lat_fixed = 0;
        run       = 1'b0;
        push_model();

        // Stray draw_done while frozen in WAIT.
        wait_after_draw();
        stray_cnt++;
        step(20);

        // Long randomised run covering every wall bounce.
        target = items_done + 2 * RAND_FRAMES;
        for (int i = 0; i < 60000 && items_done < target; i++) begin
            run = ($urandom_range(0, 3) != 0);
            step(1);
        end
        if (items_done < target) timeout_req++;
        run = 1'b1;
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
